// File: rtl/fe_fetch_stage.sv
// fe_fetch_stage: fetch-stage PC generator and FE pipeline latch.
// Produces the instruction-memory fetch address and latches
// {valid, inst, pc, pc+4, seq} for decode. An execute-stage redirect
// squashes the wrong-path fetch with a one-cycle bubble. A decode stall
// freezes the PC and the latch.
// Optional feature macro: FE_PERF_CNT_EN adds the saturating counters
// perf_redirects and perf_stall_cycles.
module fe_fetch_stage #(
   parameter int               DBITS    = 32,
   parameter int               INSTBITS = 32,
   parameter logic [DBITS-1:0] STARTPC  = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                redirect_valid,
   input  logic [DBITS-1:0]    redirect_pc,
   input  logic                stall_fe,
   output logic [DBITS-1:0]    imem_addr,
   input  logic [INSTBITS-1:0] imem_data,
   output logic                fe_valid,
   output logic [INSTBITS-1:0] fe_inst,
   output logic [DBITS-1:0]    fe_pc,
   output logic [DBITS-1:0]    fe_pcplus,
   output logic [DBITS-1:0]    fe_inst_count
`ifdef FE_PERF_CNT_EN
   ,
   output logic [31:0]         perf_redirects,
   output logic [31:0]         perf_stall_cycles
`endif
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t               state_q;
   logic [DBITS-1:0]     pc_q;
   logic                 fe_valid_q;
   logic [INSTBITS-1:0]  fe_inst_q;
   logic [DBITS-1:0]     fe_pc_q;
   logic [DBITS-1:0]     fe_pcplus_q;
   logic [DBITS-1:0]     fe_cnt_q;
   logic [DBITS-1:0]     seq_q;

   // Incremented values; both wrap silently at 2^DBITS.
   logic [DBITS-1:0]     pc_d;
   logic [DBITS-1:0]     seq_d;
   assign pc_d  = pc_q + DBITS'(4);
   assign seq_d = seq_q + DBITS'(1);

   // BOOT ignores both redirect and stall; RUN and HOLD share one priority.
   logic active;
   logic redirect_apply;
   logic stall_apply;
   assign active         = (state_q == S_RUN) || (state_q == S_HOLD);
   assign redirect_apply = active && redirect_valid;
   assign stall_apply    = active && !redirect_valid && stall_fe;

   // PC, FE latch, sequence counter and FSM: redirect > stall > fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_BOOT;
         pc_q        <= STARTPC;
         fe_valid_q  <= 1'b0;
         fe_inst_q   <= '0;
         fe_pc_q     <= '0;
         fe_pcplus_q <= '0;
         fe_cnt_q    <= '0;
         seq_q       <= '0;
      end else begin
         case (state_q)
            S_BOOT: begin
               state_q <= S_RUN;
            end
            S_RUN, S_HOLD: begin
               if (redirect_apply) begin
                  // Squash: the target is fetched next cycle; seq is kept.
                  pc_q       <= redirect_pc;
                  fe_valid_q <= 1'b0;
                  state_q    <= S_RUN;
               end else if (stall_apply) begin
                  // Latch (live or bubble) and PC are frozen.
                  state_q <= S_HOLD;
               end else begin
                  fe_valid_q  <= 1'b1;
                  fe_inst_q   <= imem_data;
                  fe_pc_q     <= pc_q;
                  fe_pcplus_q <= pc_d;
                  fe_cnt_q    <= seq_q;
                  pc_q        <= pc_d;
                  seq_q       <= seq_d;
                  state_q     <= S_RUN;
               end
            end
            default: begin
               state_q <= S_BOOT;
            end
         endcase
      end
   end

   assign imem_addr     = pc_q;
   assign fe_valid      = fe_valid_q;
   assign fe_inst       = fe_inst_q;
   assign fe_pc         = fe_pc_q;
   assign fe_pcplus     = fe_pcplus_q;
   assign fe_inst_count = fe_cnt_q;

`ifdef FE_PERF_CNT_EN
   logic [31:0] perf_redirects_q;
   logic [31:0] perf_stall_q;

   // Saturating event counters for applied redirects and stalled edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_redirects_q <= '0;
         perf_stall_q     <= '0;
      end else begin
         if (redirect_apply && (perf_redirects_q != 32'hFFFF_FFFF))
            perf_redirects_q <= perf_redirects_q + 32'd1;
         if (stall_apply && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_redirects    = perf_redirects_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Directed testbench for fe_fetch_stage. The instruction memory returns
// ~address, so every expected instruction word is hand-derivable.
module tb_fe_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_fe;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        fe_valid;
   logic [31:0] fe_inst;
   logic [31:0] fe_pc;
   logic [31:0] fe_pcplus;
   logic [31:0] fe_inst_count;
`ifdef FE_PERF_CNT_EN
   logic [31:0] perf_redirects;
   logic [31:0] perf_stall_cycles;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign imem_data = ~imem_addr;

   fe_fetch_stage #(
      .DBITS   (32),
      .INSTBITS(32),
      .STARTPC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .stall_fe      (stall_fe),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .fe_valid      (fe_valid),
      .fe_inst       (fe_inst),
      .fe_pc         (fe_pc),
      .fe_pcplus     (fe_pcplus),
      .fe_inst_count (fe_inst_count)
`ifdef FE_PERF_CNT_EN
      ,
      .perf_redirects   (perf_redirects),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_bubble(input string tag, input logic [31:0] addr);
      check({tag, ".valid"}, {31'd0, fe_valid}, 32'd0);
      check({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic expect_latch(input string tag, input logic [31:0] pc,
                               input logic [31:0] cnt, input logic [31:0] addr);
      check({tag, ".valid"}, {31'd0, fe_valid}, 32'd1);
      check({tag, ".inst"}, fe_inst, ~pc);
      check({tag, ".pc"}, fe_pc, pc);
      check({tag, ".pcplus"}, fe_pcplus, pc + 32'd4);
      check({tag, ".count"}, fe_inst_count, cnt);
      check({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic expect_reset(input string tag);
      check({tag, ".valid"}, {31'd0, fe_valid}, 32'd0);
      check({tag, ".inst"}, fe_inst, 32'd0);
      check({tag, ".pc"}, fe_pc, 32'd0);
      check({tag, ".pcplus"}, fe_pcplus, 32'd0);
      check({tag, ".count"}, fe_inst_count, 32'd0);
      check({tag, ".addr"}, imem_addr, 32'd0);
`ifdef FE_PERF_CNT_EN
      check({tag, ".perf_redir"}, perf_redirects, 32'd0);
      check({tag, ".perf_stall"}, perf_stall_cycles, 32'd0);
`endif
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      stall_fe = 1'b0;
      step();
      step();
      expect_reset("reset0");

      // Release: one BOOT bubble, then sequential fetch at 1/cycle.
      reset = 1'b0;
      step();
      expect_bubble("boot0", 32'h0);
      step();
      expect_latch("fetch0", 32'h0, 32'd0, 32'h4);
      step();
      expect_latch("fetch4", 32'h4, 32'd1, 32'h8);
      step();
      expect_latch("fetch8", 32'h8, 32'd2, 32'hC);

      // Three stalled edges freeze everything.
      stall_fe = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_latch("stall", 32'h8, 32'd2, 32'hC);
      end
      stall_fe = 1'b0;
      step();
      expect_latch("unstall", 32'hC, 32'd3, 32'h10);
`ifdef FE_PERF_CNT_EN
      check("perf_stall3", perf_stall_cycles, 32'd3);
`endif

      // Redirect wins over a simultaneous stall.
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      stall_fe = 1'b1;
      step();
      expect_bubble("redir200", 32'h200);
      redirect_valid = 1'b0;
      stall_fe = 1'b0;
      step();
      expect_latch("tgt200", 32'h200, 32'd4, 32'h204);

      // A bubble is held (not refetched) under stall.
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      step();
      expect_bubble("redir300", 32'h300);
      redirect_valid = 1'b0;
      stall_fe = 1'b1;
      step();
      expect_bubble("bubble_hold", 32'h300);
      stall_fe = 1'b0;
      step();
      expect_latch("tgt300", 32'h300, 32'd5, 32'h304);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      expect_bubble("redir_top", 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      step();
      expect_latch("wrap", 32'hFFFF_FFFC, 32'd6, 32'h0);

      // Reset while in HOLD.
      stall_fe = 1'b1;
      step();
      expect_latch("hold_pre_rst", 32'hFFFF_FFFC, 32'd6, 32'h0);
      reset = 1'b1;
      step();
      expect_reset("rst_hold");
      reset = 1'b0;
      stall_fe = 1'b0;
      step();
      expect_bubble("boot1", 32'h0);
      step();
      expect_latch("refetch0", 32'h0, 32'd0, 32'h4);

      // Reset during a redirect bubble.
      redirect_valid = 1'b1;
      redirect_pc = 32'h400;
      step();
      expect_bubble("redir400", 32'h400);
      redirect_valid = 1'b0;
      reset = 1'b1;
      step();
      expect_reset("rst_bubble");

      // BOOT ignores redirect and stall.
      reset = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h500;
      stall_fe = 1'b1;
      step();
      expect_bubble("boot_ignore", 32'h0);
      redirect_valid = 1'b0;
      stall_fe = 1'b0;
      step();
      expect_latch("post_boot", 32'h0, 32'd0, 32'h4);

      // Five back-to-back redirects: bubbles throughout, seq untouched.
      redirect_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         redirect_pc = 32'h600 + 32'(i) * 32'h10;
         step();
         expect_bubble("redir_b2b", 32'h600 + 32'(i) * 32'h10);
      end
`ifdef FE_PERF_CNT_EN
      check("perf_redir5", perf_redirects, 32'd5);
`endif
      redirect_valid = 1'b0;
      step();
      expect_latch("after_b2b", 32'h640, 32'd1, 32'h644);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fe_fetch_stage.md
# fe_fetch_stage

Fetch-stage PC generator and FE pipeline latch for the five-stage in-order RISC-V pipeline. It is the receiving end of the execute-stage redirect: it consumes the branch/jump redirect (taken flag plus target PC) and the decode-stage stall. It drives instruction memory and presents {valid, inst, PC, PC+4, instruction count} to decode. All state changes on `clk`; wrong-path fetch is squashed by inserting a bubble.

## Interface
- `DBITS`, 32, data/PC width
- `INSTBITS`, 32, instruction width
- `STARTPC`, 32'h0000_0000, PC loaded at reset
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `redirect_valid`  in  1  execute stage resolved a taken branch/jump this cycle
- `redirect_pc`  in  DBITS  redirect target; meaningful only when `redirect_valid`=1
- `stall_fe`  in  1  decode cannot accept a new FE latch this cycle
- `imem_addr`  out  DBITS  fetch address; equals current PC register
- `imem_data`  in  INSTBITS  instruction at `imem_addr`, combinational same-cycle read
- `fe_valid`  out  1  FE latch holds a live instruction
- `fe_inst`  out  INSTBITS  latched instruction
- `fe_pc`  out  DBITS  PC of latched instruction
- `fe_pcplus`  out  DBITS  `fe_pc`+4
- `fe_inst_count`  out  DBITS  fetch sequence number of latched instruction
- `perf_redirects`  out  32  redirects taken (only with `FE_PERF_CNT_EN`)
- `perf_stall_cycles`  out  32  cycles spent in HOLD (only with `FE_PERF_CNT_EN`)

## Operation
- State: PC register, FE latch, sequence counter `seq`, FSM {BOOT, RUN, HOLD}.
- Reset (any cycle, including mid-stall or mid-redirect): PC<=STARTPC, all FE latch fields<=0, `seq`<=0, FSM<=BOOT, perf counters<=0.
- BOOT: one cycle, `fe_valid`=0, no latch update, PC unchanged; -> RUN unconditionally (redirect/stall ignored in BOOT).
- RUN, priority order at each edge:
  1. `redirect_valid`=1: PC<=`redirect_pc`; `fe_valid`<=0 (other FE fields don't care, hold); `seq` unchanged; FSM stays RUN. Overrides `stall_fe`.
  2. `stall_fe`=1: PC and FE latch hold; FSM->HOLD.
  3. else: FE latch<={1, `imem_data`, PC, PC+4, `seq`}; PC<=PC+4; `seq`<=`seq`+1.
- HOLD: same priority as RUN. Redirect -> RUN with bubble as above. `stall_fe`=1 -> stay HOLD, everything held. `stall_fe`=0 -> perform a normal fetch (rule 3) and -> RUN.
- Arithmetic: PC+4 and `seq`+1 wrap modulo 2^DBITS silently; `redirect_pc` taken verbatim (no alignment check, low bits passed through).
- `seq` counts fetched-and-latched instructions; squashed ones still consume a number, so gaps after redirects are legal.
- A bubble latched with `fe_valid`=0 still responds to `stall_fe` (held, not refetched).

## Timing
- All outputs registered except `imem_addr` (= PC register, no combinational path from inputs).
- Fetch-to-latch latency 1 cycle; redirect penalty 1 bubble: edge N sees redirect, cycle N+1 `imem_addr`=target with `fe_valid`=0, edge N+1 latches target instruction.
- Sustained throughput 1 instruction/cycle with no stall and no redirect.
- Reset values: `imem_addr`=STARTPC, `fe_valid`=0, `fe_inst`=0, `fe_pc`=0, `fe_pcplus`=0, `fe_inst_count`=0, perf counters 0.

## Configuration
- `FE_PERF_CNT_EN` defined: `perf_redirects` increments on each edge applying a redirect (RUN or HOLD); `perf_stall_cycles` increments on each edge spent in or entering HOLD with `stall_fe`=1; both saturate at 32'hFFFF_FFFF.
- Not defined: both ports and counters absent; all other behaviour identical.

## Test plan
- Reset then release, `imem_data`=mem[addr/4]: cycle 0 after release `fe_valid`=0 (BOOT); next edges latch PCs 0x0,0x4,0x8 with `fe_inst_count` 0,1,2.
- `stall_fe`=1 for 3 cycles while latch holds PC 0x8: latch and `imem_addr`=0xC frozen; on release latch PC 0xC, count 3; perf stall count = 3.
- `redirect_valid`=1, `redirect_pc`=0x200 with `stall_fe`=1 same cycle: next cycle `fe_valid`=0, `imem_addr`=0x200; following edge latches PC 0x200, `fe_pcplus`=0x204.
- PC at 0xFFFF_FFFC, no stall: latch PC 0xFFFF_FFFC, `fe_pcplus`=0x0, next `imem_addr`=0x0.
- Assert `reset` during HOLD and during redirect bubble: next cycle all outputs at reset values, `imem_addr`=STARTPC, BOOT bubble follows.
- With `FE_PERF_CNT_EN`, 5 back-to-back redirects: `perf_redirects`=5, `fe_valid`=0 throughout, `seq` unchanged.
